pwl_eval_pipe: RTL
==================

Name: pwl_eval_pipe

Overview:
- Parametrised, pipelined piecewise-linear function evaluator: y = M[s]*x + C[s], where s is the segment selected by comparing x against a breakpoint table.
- Successor to the fixed 8-region combinational softplus-derivative approximator. Adds a run-time programmable table, valid/ready handshake, output saturation and a sideband tag.
- Sits directly after the softplus stage in the activation/gradient datapath.
- Reset loads the legacy derivative table, so behaviour after reset matches the previous block, with saturation added.

Parameters:
- DATA_W, 20: signed width of x and y (LSB = 2^-15 in the default configuration).
- N_SEG, 8: number of segments. Power of two, 2..16.
- SLOPE_W, 10: signed width of slope M.
- SLOPE_FRAC, 0: fractional bits of M. The product is arithmetically right-shifted by this amount.
- TAG_W, 4: width of the sideband tag carried alongside each sample.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts the sample this cycle.
- in_x  in  DATA_W  signed input.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_y  out  DATA_W  signed result.
- out_tag  out  TAG_W  tag of the result.
- out_sat  out  1  result was saturated.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  clog2(N_SEG)  segment index to write.
- cfg_bp  in  DATA_W  upper breakpoint of the segment (inclusive).
- cfg_m  in  SLOPE_W  slope of the segment.
- cfg_c  in  DATA_W  offset of the segment.
- cfg_ready  out  1  high when the pipeline is empty, so a write is allowed.

Behaviour:
- Reset:
  - out_valid=0, out_y=0, out_tag=0, out_sat=0; all stage valids cleared.
  - Table loaded with the default contents:
    - bp = 1, 6, 10, 16, 24, 40, 72, max.
    - M = 192, 48, 32, 26, 20, 16, 12, 10.
    - C = 0x00000, 0x000A7, 0x00105, 0x00140, 0x001A0, 0x00200, 0x002A0, 0x00330.
  - For N_SEG != 8, the default table is the first N_SEG entries, padded with the last entry.
  - Reset mid-operation discards all in-flight samples without producing output.
- Segment select: s = lowest i with x <= bp[i] (signed compare). If no entry matches, s = N_SEG-1. bp[N_SEG-1] is ignored. Negative x selects segment 0 under the default table.
- Pipeline, 3 stages:
  - S1 registers x, tag and s.
  - S2 registers the full product x*M[s] (DATA_W+SLOPE_W bits) and C[s].
  - S3 shifts the product right arithmetically by SLOPE_FRAC (floor), adds sign-extended C, saturates to DATA_W, and registers out_y, out_sat and out_tag.
- Latency: 3 cycles from input handshake to out_valid when not stalled. Throughput: 1 sample/clock.
- Saturation:
  - Result > 2^(DATA_W-1)-1 gives max positive with out_sat=1.
  - Result < -2^(DATA_W-1) gives min negative with out_sat=1.
  - Otherwise out_sat=0.
- Backpressure:
  - When out_valid & !out_ready, the whole pipeline holds and out_* stay stable.
  - in_ready = !(out_valid & !out_ready) & !cfg_we.
  - Bubbles are not compressed: the pipeline advances in lockstep.
- Handshakes: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Configuration:
  - cfg_ready=1 only when all three stage valids are 0.
  - A write happens only when cfg_we & cfg_ready; cfg_we while cfg_ready=0 is ignored with no side effect.
  - A written entry is used by samples accepted on the following cycle or later.
  - In any cycle with cfg_we=1, no sample is accepted, because in_ready=0.
- Breakpoint ordering: a non-monotonic table is legal. The lowest-index-match rule still applies.

Decomposition:
- Package pwl_pkg holds:
  - default table constants (DEF_BP, DEF_M, DEF_C);
  - the saturate function;
  - the segment-index width helper.
- One sub-module, pwl_seg_select: combinational priority comparator that maps x and the breakpoint vector to s.

Test Plan:
- After reset with the default table, drive x = 0x00001, 0x00008, 0x00100, 0xFFFFF, one per cycle, with out_ready=1. Required: y = 0x000C0, 0x00205, 0x00D30, 0xFFF40 on cycles 3–6, out_sat=0, tags match.
- x=0x7FFFF with default table → y=0x7FFFF, out_sat=1; x=0x80000 → y=0x80000, out_sat=1.
- Stream 10 samples with out_ready toggled 1,0,0,1,…. Required: no sample lost or duplicated, out_* stable while stalled, in_ready low during stalls.
- cfg_we with the pipeline busy → ignored, table unchanged. After drain, write idx 0 with bp=1, m=-2, c=0x00010, then send x=1 → y=0x0000E.
- SLOPE_FRAC=2 build: M=3 in segment 0, x=-1 → floor(-3/4) = -1 → y=C[0]-1.
- Assert rst while 3 samples are in flight → no out_valid afterwards, table restored to the defaults.

Source files
------------

// File: rtl/pwl_pkg.sv
// Shared constants and helpers for the piecewise-linear evaluator.
package pwl_pkg;

    localparam int NDEF = 8;

    // Legacy softplus-derivative table; the last breakpoint stands in for "max".
    localparam int DEF_BP [NDEF] = '{1, 6, 10, 16, 24, 40, 72, 32'h7FFF_FFFF};
    localparam int DEF_M  [NDEF] = '{192, 48, 32, 26, 20, 16, 12, 10};
    localparam int DEF_C  [NDEF] = '{'h000, 'h0A7, 'h105, 'h140, 'h1A0, 'h200, 'h2A0, 'h330};

    // Width of a segment index.
    function automatic int unsigned seg_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default-table row for segment i; rows past the legacy table repeat the last one.
    function automatic int unsigned def_idx(input int unsigned i);
        return (i < NDEF) ? i : NDEF - 1;
    endfunction

    // Clamp v to a w-bit signed range. Returns {sat, clamped value}.
    function automatic logic [64:0] saturate(input logic signed [63:0] v, input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return {1'b1, hi};
        end else if (v < lo) begin
            return {1'b1, lo};
        end
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/pwl_seg_select.sv
// Priority comparator: lowest segment whose breakpoint is >= x, else the last segment.
module pwl_seg_select
    import pwl_pkg::*;
#(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned N_SEG  = 8
) (
    input  logic [DATA_W-1:0]              i_x,
    input  logic [(N_SEG-1)*DATA_W-1:0]    i_bp,
    output logic [seg_w(N_SEG)-1:0]        o_seg
);

    localparam int unsigned SW = seg_w(N_SEG);

    // Scan from high to low so the lowest matching index wins.
    always_comb begin
        o_seg = SW'(N_SEG - 1);
        for (int i = int'(N_SEG) - 2; i >= 0; i--) begin
            if ($signed(i_x) <= $signed(i_bp[i*DATA_W +: DATA_W])) begin
                o_seg = SW'(i);
            end
        end
    end

endmodule

// File: rtl/pwl_eval_pipe.sv
// Three-stage piecewise-linear evaluator y = M[s]*x + C[s] with a programmable table,
// lockstep valid/ready pipeline and output saturation.
module pwl_eval_pipe
    import pwl_pkg::*;
#(
    parameter int unsigned DATA_W     = 20,
    parameter int unsigned N_SEG      = 8,
    parameter int unsigned SLOPE_W    = 10,
    parameter int unsigned SLOPE_FRAC = 0,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_x,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_y,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_sat,
    input  logic                     cfg_we,
    input  logic [seg_w(N_SEG)-1:0]  cfg_idx,
    input  logic [DATA_W-1:0]        cfg_bp,
    input  logic [SLOPE_W-1:0]       cfg_m,
    input  logic [DATA_W-1:0]        cfg_c,
    output logic                     cfg_ready
);

    localparam int unsigned SW = seg_w(N_SEG);
    localparam int unsigned PW = DATA_W + SLOPE_W;
    localparam logic [DATA_W-1:0] BP_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    // Segment table
    logic [DATA_W-1:0]  r_bp [N_SEG];
    logic [SLOPE_W-1:0] r_m  [N_SEG];
    logic [DATA_W-1:0]  r_c  [N_SEG];

    // Stage registers
    logic                     r_v1, r_v2, r_v3;
    logic signed [DATA_W-1:0] r_x1;
    logic [TAG_W-1:0]         r_tag1, r_tag2, r_tag3;
    logic [SW-1:0]            r_s1;
    logic signed [PW-1:0]     r_prod2;
    logic signed [DATA_W-1:0] r_c2;
    logic [DATA_W-1:0]        r_y3;
    logic                     r_sat3;

    logic                          w_adv, w_in_fire, w_cfg_wr;
    logic [(N_SEG-1)*DATA_W-1:0]   w_bp_flat;
    logic [SW-1:0]                 w_seg;
    logic signed [PW-1:0]          w_xe, w_me, w_prod, w_shift;
    logic signed [63:0]            w_sum;
    logic [64:0]                   w_sat_res;
    logic                          w_unused;

    // The whole pipeline freezes while the output is held by the consumer.
    assign w_adv     = !(r_v3 && !out_ready);
    assign in_ready  = w_adv && !cfg_we;
    assign w_in_fire = in_valid && in_ready;
    assign cfg_ready = !(r_v1 || r_v2 || r_v3);
    assign w_cfg_wr  = cfg_we && cfg_ready;

    // Flatten the breakpoints the selector looks at; the last one never matters.
    always_comb begin
        w_bp_flat = '0;
        for (int i = 0; i < int'(N_SEG) - 1; i++) begin
            w_bp_flat[i*DATA_W +: DATA_W] = r_bp[i];
        end
    end

    pwl_seg_select #(
        .DATA_W (DATA_W),
        .N_SEG  (N_SEG)
    ) u_seg_select (
        .i_x   (in_x),
        .i_bp  (w_bp_flat),
        .o_seg (w_seg)
    );

    // Full-width signed product and arithmetic scaling/offset/clamp.
    assign w_xe      = {{SLOPE_W{r_x1[DATA_W-1]}}, r_x1};
    assign w_me      = {{DATA_W{r_m[r_s1][SLOPE_W-1]}}, r_m[r_s1]};
    assign w_prod    = w_xe * w_me;
    assign w_shift   = r_prod2 >>> SLOPE_FRAC;
    assign w_sum     = 64'(w_shift) + 64'(r_c2);
    assign w_sat_res = saturate(w_sum, DATA_W);
    assign w_unused  = ^{w_sat_res[63:DATA_W], r_bp[N_SEG-1]};

    // Table: loads the legacy contents on reset, takes writes only when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_SEG; i++) begin
                r_bp[i] <= (def_idx(i) == NDEF - 1) ? BP_MAX : DATA_W'(DEF_BP[def_idx(i)]);
                r_m[i]  <= SLOPE_W'(DEF_M[def_idx(i)]);
                r_c[i]  <= DATA_W'(DEF_C[def_idx(i)]);
            end
        end else if (w_cfg_wr) begin
            r_bp[cfg_idx] <= cfg_bp;
            r_m[cfg_idx]  <= cfg_m;
            r_c[cfg_idx]  <= cfg_c;
        end
    end

    // Lockstep pipeline: all stages move together, bubbles included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_x1    <= '0;
            r_tag1  <= '0;
            r_s1    <= '0;
            r_prod2 <= '0;
            r_c2    <= '0;
            r_tag2  <= '0;
            r_y3    <= '0;
            r_sat3  <= 1'b0;
            r_tag3  <= '0;
        end else if (w_adv) begin
            r_v1 <= w_in_fire;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (w_in_fire) begin
                r_x1   <= in_x;
                r_tag1 <= in_tag;
                r_s1   <= w_seg;
            end
            if (r_v1) begin
                r_prod2 <= w_prod;
                r_c2    <= r_c[r_s1];
                r_tag2  <= r_tag1;
            end
            if (r_v2) begin
                r_y3   <= w_sat_res[DATA_W-1:0];
                r_sat3 <= w_sat_res[64];
                r_tag3 <= r_tag2;
            end
        end
    end

    assign out_valid = r_v3;
    assign out_y     = r_y3;
    assign out_tag   = r_tag3;
    assign out_sat   = r_sat3;

endmodule
